// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the RAM port arbiter (mem_arbiter).
package mem_arb_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_e;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_EXT = 1'b1
    } gnt_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Requester selection for mem_arbiter: owns last_grant and resolves conflicts.
// Build option: MEM_ARB_FIXED_PRIO_EN makes EXT win every conflict
// (last_grant is still tracked); otherwise conflicts are round-robin.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_cpu_req,
    input  logic i_ext_req,
    input  logic i_take,
    output logic o_valid_c,
    output gnt_e o_pick_c,
    output gnt_e o_last_gnt
);

    gnt_e r_last_gnt;

    // Choose a requester; on conflict favour the side not served last
    always_comb begin
        o_valid_c = i_cpu_req | i_ext_req;
        o_pick_c  = GNT_CPU;
        if (i_cpu_req && i_ext_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            o_pick_c = GNT_EXT;
`else
            o_pick_c = (r_last_gnt == GNT_EXT) ? GNT_CPU : GNT_EXT;
`endif
        end else if (i_ext_req) begin
            o_pick_c = GNT_EXT;
        end
    end

    // Remember the most recent grant; reset value lets CPU win the first conflict
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_gnt <= GNT_EXT;
        end else if (i_take) begin
            r_last_gnt <= o_pick_c;
        end
    end

    assign o_last_gnt = r_last_gnt;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous RAM port between the CPU sequencer and an external
// loader/debug port, with WAIT_CYCLES extra hold cycles and a one-cycle ACK.
// Build option: MEM_ARB_FIXED_PRIO_EN (see mem_arb_pick).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 11,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_ack,
    input  logic              i_ext_req,
    input  logic              i_ext_we,
    input  logic [ADDR_W-1:0] i_ext_addr,
    input  logic [DATA_W-1:0] i_ext_wdata,
    output logic [DATA_W-1:0] o_ext_rdata,
    output logic              o_ext_ack,
    output logic              o_hold_c,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    state_e             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_mem_en, w_mem_en_nxt;
    logic               r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0]  r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0]  r_mem_wdata, w_mem_wdata_nxt;
    logic [DATA_W-1:0]  r_cpu_rdata, w_cpu_rdata_nxt;
    logic [DATA_W-1:0]  r_ext_rdata, w_ext_rdata_nxt;
    logic               r_cpu_ack, w_cpu_ack_nxt;
    logic               r_ext_ack, w_ext_ack_nxt;
    logic               w_valid;
    logic               w_take;
    gnt_e               w_pick;
    gnt_e               w_gnt;

    mem_arb_pick u_pick (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_cpu_req  (i_cpu_req),
        .i_ext_req  (i_ext_req),
        .i_take     (w_take),
        .o_valid_c  (w_valid),
        .o_pick_c   (w_pick),
        .o_last_gnt (w_gnt)
    );

    assign w_take = (r_state == ST_IDLE) && w_valid;

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_mem_en_nxt    = r_mem_en;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_cpu_rdata_nxt = r_cpu_rdata;
        w_ext_rdata_nxt = r_ext_rdata;
        w_cpu_ack_nxt   = 1'b0;
        w_ext_ack_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_mem_en_nxt = 1'b0;
                w_mem_we_nxt = 1'b0;
                if (w_take) begin
                    w_mem_en_nxt = 1'b1;
                    w_cnt_nxt    = CNT_W'(WAIT_CYCLES);
                    w_state_nxt  = ST_ACCESS;
                    if (w_pick == GNT_EXT) begin
                        w_mem_we_nxt    = i_ext_we;
                        w_mem_addr_nxt  = i_ext_addr;
                        w_mem_wdata_nxt = i_ext_wdata;
                    end else begin
                        w_mem_we_nxt    = i_cpu_we;
                        w_mem_addr_nxt  = i_cpu_addr;
                        w_mem_wdata_nxt = i_cpu_wdata;
                    end
                end
            end
            ST_ACCESS: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_mem_en_nxt = 1'b0;
                    w_mem_we_nxt = 1'b0;
                    w_state_nxt  = ST_DONE;
                    if (w_gnt == GNT_EXT) begin
                        w_ext_rdata_nxt = i_mem_rdata;
                        w_ext_ack_nxt   = 1'b1;
                    end else begin
                        w_cpu_rdata_nxt = i_mem_rdata;
                        w_cpu_ack_nxt   = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_mem_en_nxt = 1'b0;
                w_mem_we_nxt = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered datapath and outputs; reset abandons any access in flight
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt       <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_rdata <= '0;
            r_ext_rdata <= '0;
            r_cpu_ack   <= 1'b0;
            r_ext_ack   <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_cpu_rdata <= w_cpu_rdata_nxt;
            r_ext_rdata <= w_ext_rdata_nxt;
            r_cpu_ack   <= w_cpu_ack_nxt;
            r_ext_ack   <= w_ext_ack_nxt;
        end
    end

    assign o_mem_en    = r_mem_en;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_cpu_rdata = r_cpu_rdata;
    assign o_ext_rdata = r_ext_rdata;
    assign o_cpu_ack   = r_cpu_ack;
    assign o_ext_ack   = r_ext_ack;
    assign o_hold_c    = i_cpu_req & ~r_cpu_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scoreboard of expected read data per
// port, plus timing checks. Honours MEM_ARB_FIXED_PRIO_EN for grant order.
module tb_mem_arbiter;

    localparam int unsigned AW = 11;
    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_req, cpu_we, ext_req, ext_we;
    logic [AW-1:0] cpu_addr, ext_addr;
    logic [DW-1:0] cpu_wdata, ext_wdata, cpu_rdata, ext_rdata;
    logic          cpu_ack, ext_ack, hold;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic          z_cpu_req;
    logic [DW-1:0] z_cpu_rdata, z_ext_rdata;
    logic          z_cpu_ack, z_ext_ack, z_hold;
    logic          z_mem_en, z_mem_we;
    logic [AW-1:0] z_mem_addr;
    logic [DW-1:0] z_mem_wdata, z_mem_rdata;

    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_data;
    logic [DW-1:0] ram [0:(1<<AW)-1];

    int            n_checks, n_fail;
    int            cpu_acks, ext_acks, we_cycles;
    logic [16:0]   q_cpu[$];
    logic [16:0]   q_ext[$];
    bit            ack_log[$];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
        .i_cpu_wdata(cpu_wdata), .o_cpu_rdata(cpu_rdata), .o_cpu_ack(cpu_ack),
        .i_ext_req(ext_req), .i_ext_we(ext_we), .i_ext_addr(ext_addr),
        .i_ext_wdata(ext_wdata), .o_ext_rdata(ext_rdata), .o_ext_ack(ext_ack),
        .o_hold_c(hold), .o_mem_en(mem_en), .o_mem_we(mem_we),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cpu_req(z_cpu_req), .i_cpu_we(1'b0), .i_cpu_addr(11'd7),
        .i_cpu_wdata(16'h0000), .o_cpu_rdata(z_cpu_rdata), .o_cpu_ack(z_cpu_ack),
        .i_ext_req(1'b0), .i_ext_we(1'b0), .i_ext_addr(11'd0),
        .i_ext_wdata(16'h0000), .o_ext_rdata(z_ext_rdata), .o_ext_ack(z_ext_ack),
        .o_hold_c(z_hold), .o_mem_en(z_mem_en), .o_mem_we(z_mem_we),
        .o_mem_addr(z_mem_addr), .o_mem_wdata(z_mem_wdata), .i_mem_rdata(z_mem_rdata)
    );

    // RAM model: synchronous write, read data valid as soon as the address is
    always @(posedge clk) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        else if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    end
    assign mem_rdata   = ram[mem_addr];
    assign z_mem_rdata = DW'(z_mem_addr) ^ 16'h5A00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: pop per-port expectations on every ACK
    task automatic monitor_loop();
        logic [16:0] e;
        forever begin
            @(negedge clk);
            if (mem_we) we_cycles++;
            if (cpu_ack || ext_ack) chk("ack_excl", 32'(cpu_ack & ext_ack), 0);
            if (z_cpu_ack || z_ext_ack) chk("z_ack_excl", 32'(z_ext_ack), 0);
            if (cpu_ack) begin
                cpu_acks++;
                ack_log.push_back(1'b0);
                if (q_cpu.size() == 0) chk("cpu_ack_unexpected", 1, 0);
                else begin
                    e = q_cpu.pop_front();
                    if (!e[16]) chk("cpu_rdata", 32'(cpu_rdata), 32'(e[15:0]));
                end
            end
            if (ext_ack) begin
                ext_acks++;
                ack_log.push_back(1'b1);
                if (q_ext.size() == 0) chk("ext_ack_unexpected", 1, 0);
                else begin
                    e = q_ext.pop_front();
                    if (!e[16]) chk("ext_rdata", 32'(ext_rdata), 32'(e[15:0]));
                end
            end
        end
    endtask

    // One complete request/ACK handshake on either port
    task automatic access(input bit is_ext, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] exp_rd);
        int start;
        bit got;
        @(posedge clk); #1;
        if (is_ext) begin
            ext_we = we; ext_addr = a; ext_wdata = d; ext_req = 1'b1;
            q_ext.push_back({we, exp_rd});
            start = ext_acks;
        end else begin
            cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
            q_cpu.push_back({we, exp_rd});
            start = cpu_acks;
        end
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk);
            got = is_ext ? (ext_acks > start) : (cpu_acks > start);
        end
        if (!got) chk(is_ext ? "ext_timeout" : "cpu_timeout", 1, 0);
        #1;
        if (is_ext) ext_req = 1'b0;
        else cpu_req = 1'b0;
    endtask

    initial begin
        int w0, e0, prev, nack;
        bit exp_rr[4];
        rst_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0;
        z_cpu_req = 0; bd_we = 0; bd_addr = '0; bd_data = '0;
        n_checks = 0; n_fail = 0; cpu_acks = 0; ext_acks = 0; we_cycles = 0;
        fork monitor_loop(); join_none

        // Preload RAM during reset and check reset values
        @(negedge clk); bd_we = 1; bd_addr = 11'h005; bd_data = 16'h1234;
        @(negedge clk); bd_addr = 11'h020; bd_data = 16'h2020;
        @(negedge clk); bd_addr = 11'h030; bd_data = 16'h3030;
        @(negedge clk); bd_we = 0;
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_acks", 32'({cpu_ack, ext_ack}), 0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
        chk("rst_ext_rdata", 32'(ext_rdata), 0);
        chk("rst_hold_low", 32'(hold), 0);
        cpu_req = 1; #1;
        chk("rst_hold_follows", 32'(hold), 1);
        cpu_req = 0;
        @(negedge clk); rst_n = 1'b1;

        // CPU read of 0x005 with one wait state: exact cycle timing
        @(posedge clk); #1;
        cpu_we = 0; cpu_addr = 11'h005; cpu_req = 1;
        q_cpu.push_back({1'b0, 16'h1234});
        @(negedge clk);
        chk("t1_en_pre", 32'(mem_en), 0);
        chk("t1_hold_wait", 32'(hold), 1);
        @(negedge clk);
        chk("t1_en_c1", 32'(mem_en), 1);
        chk("t1_addr", 32'(mem_addr), 32'h005);
        chk("t1_ack_c1", 32'(cpu_ack), 0);
        @(negedge clk);
        chk("t1_en_c2", 32'(mem_en), 1);
        chk("t1_ack_c2", 32'(cpu_ack), 0);
        @(negedge clk);
        chk("t1_en_done", 32'(mem_en), 0);
        chk("t1_ack", 32'(cpu_ack), 1);
        chk("t1_rdata", 32'(cpu_rdata), 32'h1234);
        chk("t1_hold_ack", 32'(hold), 0);
        @(posedge clk); #1; cpu_req = 0;
        @(negedge clk);
        chk("t1_ack_drop", 32'(cpu_ack), 0);
        chk("t1_rdata_held", 32'(cpu_rdata), 32'h1234);

        // EXT write then CPU read-back; write enable only during the write access
        w0 = we_cycles;
        access(1'b1, 1'b1, 11'h010, 16'hBEEF, 16'h0000);
        chk("t2_we_cycles", 32'(we_cycles - w0), 2);
        access(1'b0, 1'b0, 11'h010, 16'h0000, 16'hBEEF);
        chk("t2_we_after_read", 32'(we_cycles - w0), 2);

        // Both ports held for four transactions from reset
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        ack_log.delete();
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_rr = '{1'b1, 1'b1, 1'b1, 1'b1};
        repeat (4) q_ext.push_back({1'b0, 16'h3030});
`else
        exp_rr = '{1'b0, 1'b1, 1'b0, 1'b1};
        repeat (2) q_cpu.push_back({1'b0, 16'h2020});
        repeat (2) q_ext.push_back({1'b0, 16'h3030});
`endif
        @(posedge clk); #1;
        cpu_we = 0; cpu_addr = 11'h020; cpu_req = 1;
        ext_we = 0; ext_addr = 11'h030; ext_req = 1;
        for (int i = 0; i < 300 && ack_log.size() < 4; i++) @(posedge clk);
        #1;
        chk("t3_ack_count", 32'(ack_log.size()), 4);
        chk("t3_hold_end", 32'(hold), 1);
        cpu_req = 0; ext_req = 0;
        for (int i = 0; i < 4; i++)
            if (i < ack_log.size()) chk("t3_grant_order", 32'(ack_log[i]), 32'(exp_rr[i]));
        repeat (4) @(negedge clk);

        // Reset pulse in the middle of an EXT write
        @(posedge clk); #1;
        ext_we = 1; ext_addr = 11'h040; ext_wdata = 16'hAAAA; ext_req = 1;
        for (int i = 0; i < 50 && !(mem_en && mem_we); i++) @(negedge clk);
        chk("t4_write_started", 32'(mem_we), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_we_async", 32'(mem_we), 0);
        chk("t4_en_async", 32'(mem_en), 0);
        ext_req = 0;
        e0 = ext_acks;
        @(negedge clk);
        chk("t4_no_ack_rst", 32'(ext_ack), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t4_no_ack_after", 32'(ext_acks - e0), 0);
        ack_log.delete();
        fork
            access(1'b0, 1'b0, 11'h020, 16'h0000, 16'h2020);
            access(1'b1, 1'b0, 11'h030, 16'h0000, 16'h3030);
        join
        chk("t4_ack_count", 32'(ack_log.size()), 2);
`ifdef MEM_ARB_FIXED_PRIO_EN
        if (ack_log.size() > 0) chk("t4_first_grant", 32'(ack_log[0]), 1);
`else
        if (ack_log.size() > 0) chk("t4_first_grant", 32'(ack_log[0]), 0);
`endif

        // WAIT_CYCLES=0 instance with CPU_REQ held continuously
        prev = -1; nack = 0;
        @(posedge clk); #1; z_cpu_req = 1;
        for (int idx = 0; idx <= 20; idx++) begin
            @(negedge clk);
            if (idx == 1) begin
                chk("z_en_c1", 32'(z_mem_en), 1);
                chk("z_addr", 32'(z_mem_addr), 7);
                chk("z_we_c1", 32'({z_mem_we, z_mem_wdata}), 0);
            end
            if (idx == 2) chk("z_en_c2", 32'(z_mem_en), 0);
            if (z_cpu_ack) begin
                nack++;
                chk("z_rdata", 32'(z_cpu_rdata), 32'h5A07);
                chk("z_hold_ack", 32'(z_hold), 0);
                if (prev < 0) chk("z_first_ack", 32'(idx), 2);
                else chk("z_ack_gap", 32'(idx - prev), 3);
                prev = idx;
            end
        end
        z_cpu_req = 0;
        chk("z_ack_count", 32'(nack), 7);
        chk("z_ext_rdata", 32'(z_ext_rdata), 0);
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
